// File: rtl/lcd_bus_decoder_if.sv
// lcd_bus_decoder_if: HD44780 8-bit parallel bus (EN/RS/RW/DB7..DB0) as seen between
// the display writer (master) and the bus decoder (slave).
interface lcd_bus_decoder_if;
    logic       lcd_en;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;

    modport master (output lcd_en, lcd_rs, lcd_rw, lcd_data);
    modport slave  (input  lcd_en, lcd_rs, lcd_rw, lcd_data);
endinterface

// File: rtl/lcd_bus_decoder.sv
// lcd_bus_decoder: HD44780 bus responder keeping a 2x16 DDRAM shadow, cursor and display flags.
// Optional busy-time model enabled by defining LCD_BUSY_MODEL_EN.
module lcd_bus_decoder
`ifdef LCD_BUSY_MODEL_EN
#(
    parameter int unsigned BUSY_CYCLES       = 2000,
    parameter int unsigned CLEAR_BUSY_CYCLES = 82000
)
`endif
(
    input  logic                 clk,
    input  logic                 rst,
    lcd_bus_decoder_if.slave     bus,
    input  logic [4:0]           rd_addr,
    output logic [7:0]           rd_char,
    output logic [6:0]           cursor_addr,
    output logic                 display_on,
    output logic                 cursor_on,
    output logic                 func_8bit,
    output logic                 func_2line,
    output logic                 cmd_valid,
    output logic [7:0]           cmd_code,
    output logic                 char_valid,
    output logic                 busy,
    output logic                 protocol_err
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t      state_q;
    logic [4:0]  clr_idx_q;
    logic        en_q, rs_q, rw_q;
    logic [7:0]  data_q;
    logic [6:0]  ac_q;
    logic        id_q;
    logic        disp_q, cur_q, dl_q, n_q;
    logic        cmd_valid_q, char_valid_q;
    logic [7:0]  cmd_code_q;
    logic        err_q;
    logic [7:0]  shadow_q [32];
    logic [7:0]  rd_char_q;

    logic        strobe, in_clear, bad_strobe, accept, accept_cmd, accept_char;
    logic        store;
    logic [4:0]  store_idx;
    logic [6:0]  ac_step_d;
    logic        clear_home;
    logic        hold_err;

    assign strobe      = en_q & ~bus.lcd_en;
    assign in_clear    = (state_q == CLEAR);
    assign bad_strobe  = strobe & (in_clear | rw_q);
    assign accept      = strobe & ~in_clear & ~rw_q;
    assign accept_cmd  = accept & ~rs_q;
    assign accept_char = accept & rs_q;
    assign store       = accept_char & (ac_q[5:4] == 2'b00);
    assign store_idx   = {ac_q[6], ac_q[3:0]};
    assign clear_home  = accept_cmd & (data_q[7:1] == 7'b0000000 ? data_q[0] : data_q[7:1] == 7'b0000001);

    // Line 1 ends at 0x27 and line 2 at 0x67; the counter hops between lines instead of running into the gap.
    always_comb begin
        ac_step_d = ac_q;
        if (id_q) begin
            if (ac_q == 7'h27)
                ac_step_d = 7'h40;
            else if (ac_q == 7'h67)
                ac_step_d = 7'h00;
            else
                ac_step_d = ac_q + 7'd1;
        end else begin
            if (ac_q == 7'h00)
                ac_step_d = 7'h67;
            else if (ac_q == 7'h40)
                ac_step_d = 7'h27;
            else
                ac_step_d = ac_q - 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        cmd_valid_q  <= 1'b0;
        char_valid_q <= 1'b0;
        if (rst) begin
            en_q       <= 1'b0;
            rs_q       <= 1'b0;
            rw_q       <= 1'b0;
            data_q     <= 8'h00;
            state_q    <= CLEAR;
            clr_idx_q  <= 5'd0;
            ac_q       <= 7'h00;
            id_q       <= 1'b1;
            disp_q     <= 1'b0;
            cur_q      <= 1'b0;
            dl_q       <= 1'b0;
            n_q        <= 1'b0;
            cmd_code_q <= 8'h00;
            err_q      <= 1'b0;
        end else begin
            en_q   <= bus.lcd_en;
            rs_q   <= bus.lcd_rs;
            rw_q   <= bus.lcd_rw;
            data_q <= bus.lcd_data;
            if (bad_strobe | hold_err)
                err_q <= 1'b1;
            case (state_q)
                CLEAR: begin
                    clr_idx_q <= clr_idx_q + 5'd1;
                    if (clr_idx_q == 5'd31)
                        state_q <= IDLE;
                end
                IDLE: begin
                    if (accept_cmd) begin
                        cmd_valid_q <= 1'b1;
                        cmd_code_q  <= data_q;
                        casez (data_q)
                            8'b1???????: ac_q <= data_q[6:0];
                            8'b001?????: begin
                                dl_q <= data_q[4];
                                n_q  <= data_q[3];
                            end
                            8'b00001???: begin
                                disp_q <= data_q[2];
                                cur_q  <= data_q[1];
                            end
                            8'b000001??: id_q <= data_q[1];
                            8'b0000001?: ac_q <= 7'h00;
                            8'b00000001: begin
                                ac_q      <= 7'h00;
                                id_q      <= 1'b1;
                                state_q   <= CLEAR;
                                clr_idx_q <= 5'd0;
                            end
                            default: ;
                        endcase
                    end else if (accept_char) begin
                        char_valid_q <= 1'b1;
                        ac_q         <= ac_step_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Shadow RAM has no reset of its own: the clear sweep started by rst fills it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (in_clear)
                shadow_q[clr_idx_q] <= 8'h20;
            else if (store)
                shadow_q[store_idx] <= data_q;
        end
        rd_char_q <= shadow_q[rd_addr];
    end

`ifdef LCD_BUSY_MODEL_EN
    localparam int HOLD_W = $clog2(CLEAR_BUSY_CYCLES + 1);

    logic [HOLD_W-1:0] hold_q;

    assign hold_err = accept & (hold_q != '0);
    assign busy     = in_clear | (hold_q != '0);

    always_ff @(posedge clk) begin
        if (rst)
            hold_q <= '0;
        else if (accept)
            hold_q <= clear_home ? HOLD_W'(CLEAR_BUSY_CYCLES) : HOLD_W'(BUSY_CYCLES);
        else if (hold_q != '0)
            hold_q <= hold_q - 1'b1;
    end
`else
    logic unused_clear_home;

    assign unused_clear_home = clear_home;
    assign hold_err          = 1'b0;
    assign busy              = in_clear;
`endif

    assign rd_char      = rd_char_q;
    assign cursor_addr  = ac_q;
    assign display_on   = disp_q;
    assign cursor_on    = cur_q;
    assign func_8bit    = dl_q;
    assign func_2line   = n_q;
    assign cmd_valid    = cmd_valid_q;
    assign cmd_code     = cmd_code_q;
    assign char_valid   = char_valid_q;
    assign protocol_err = err_q;

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// tb_lcd_bus_decoder: directed and randomized checks of lcd_bus_decoder against a
// position-based model of the HD44780 address counter and a 32-byte shadow array.
module tb_lcd_bus_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rd_addr;
    logic [7:0] rd_char;
    logic [6:0] cursor_addr;
    logic       display_on, cursor_on, func_8bit, func_2line;
    logic       cmd_valid, char_valid, busy, protocol_err;
    logic [7:0] cmd_code;

    lcd_bus_decoder_if bus ();

    lcd_bus_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .rd_addr      (rd_addr),
        .rd_char      (rd_char),
        .cursor_addr  (cursor_addr),
        .display_on   (display_on),
        .cursor_on    (cursor_on),
        .func_8bit    (func_8bit),
        .func_2line   (func_2line),
        .cmd_valid    (cmd_valid),
        .cmd_code     (cmd_code),
        .char_valid   (char_valid),
        .busy         (busy),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;
    int cmdPulses   = 0;
    int charPulses  = 0;

    // Reference state
    logic [7:0] mShadow [32];
    int         mAc;
    bit         mId, mDisp, mCur, m8, m2, mErr;
    logic [7:0] mCode;
    int         mCmds, mChars;

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            cmdPulses  <= 0;
            charPulses <= 0;
        end else begin
            if (cmd_valid === 1'b1)  cmdPulses  <= cmdPulses + 1;
            if (char_valid === 1'b1) charPulses <= charPulses + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Visible DDRAM is two 40-cell lines laid end to end as one 80-cell ring.
    function automatic int stepAc(input int ac, input bit inc);
        int pos;
        if (ac <= 'h27 || (ac >= 'h40 && ac <= 'h67)) begin
            pos = (ac >= 'h40) ? ac - 'h40 + 40 : ac;
            pos = inc ? (pos + 1) % 80 : (pos + 79) % 80;
            return (pos >= 40) ? pos - 40 + 'h40 : pos;
        end
        return inc ? (ac + 1) % 128 : (ac + 127) % 128;
    endfunction

    task automatic modelClear();
        for (int i = 0; i < 32; i++) mShadow[i] = 8'h20;
        mAc = 0;
        mId = 1'b1;
    endtask

    task automatic modelReset();
        modelClear();
        mDisp = 0; mCur = 0; m8 = 0; m2 = 0; mErr = 0;
        mCode = 8'h00; mCmds = 0; mChars = 0;
    endtask

    task automatic modelStrobe(input bit rs, input logic [7:0] data);
        int hb;
        if (rs) begin
            if ((mAc % 64) < 16) mShadow[(mAc / 64) * 16 + (mAc % 64)] = data;
            mAc = stepAc(mAc, mId);
            mChars++;
        end else begin
            mCmds++;
            mCode = data;
            hb = -1;
            for (int b = 0; b < 8; b++) if (data[b]) hb = b;
            case (hb)
                7: mAc = int'(data) - 128;
                5: begin m8 = data[4]; m2 = data[3]; end
                3: begin mDisp = data[2]; mCur = data[1]; end
                2: mId = data[1];
                1: mAc = 0;
                0: modelClear();
                default: ;
            endcase
        end
    endtask

    task automatic applyStimulus(input bit rs, input bit rw, input logic [7:0] data);
        @(negedge clk);
        bus.lcd_rs   = rs;
        bus.lcd_rw   = rw;
        bus.lcd_data = data;
        bus.lcd_en   = 1'b1;
        @(negedge clk);
        bus.lcd_en   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitNotBusy();
        int  n = 0;
        while (busy !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) checkOutput("busy_timeout", 1, 0);
    endtask

    task automatic readShadow(input int idx, output logic [7:0] obs);
        @(negedge clk);
        rd_addr = 5'(idx);
        @(posedge clk);
        #1;
        obs = rd_char;
    endtask

    task automatic checkShadowAll(input string tag);
        logic [7:0] obs;
        for (int i = 0; i < 32; i++) begin
            readShadow(i, obs);
            checkOutput($sformatf("%s_rd_char[%0d]", tag, i), obs, mShadow[i]);
        end
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, "_cursor"}, cursor_addr, mAc);
        checkOutput({tag, "_cmd_code"}, cmd_code, mCode);
        checkOutput({tag, "_display_on"}, display_on, mDisp);
        checkOutput({tag, "_cursor_on"}, cursor_on, mCur);
        checkOutput({tag, "_func_8bit"}, func_8bit, m8);
        checkOutput({tag, "_func_2line"}, func_2line, m2);
        checkOutput({tag, "_protocol_err"}, protocol_err, mErr);
    endtask

    task automatic sendAndModel(input bit rs, input logic [7:0] data);
        applyStimulus(rs, 1'b0, data);
        modelStrobe(rs, data);
    endtask

    initial begin
        logic [7:0] obs;
        logic [7:0] oldVal;
        logic [7:0] data;
        bit         rs;
        int         busyCount;
        bit         done;

        rst = 1'b1;
        rd_addr = 5'd0;
        bus.lcd_en = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_data = 8'h00;
        modelReset();

        // 1: reset and clear sweep
        @(posedge clk);
        #1 rst = 1'b0;
        busyCount = 0;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busyCount++;
            else done = 1;
        end
        checkOutput("reset_busy_cycles", busyCount, 32);
        checkState("reset");
        checkShadowAll("reset");

        // 2: init command sequence
        sendAndModel(1'b0, 8'h38);
        checkOutput("cmd_valid_pulse", cmd_valid, 1);
        @(posedge clk); #1;
        checkOutput("cmd_valid_drop", cmd_valid, 0);
        idle(100);
        sendAndModel(1'b0, 8'h0E); idle(100);
        sendAndModel(1'b0, 8'h01); idle(100);
        sendAndModel(1'b0, 8'h02); idle(100);
        sendAndModel(1'b0, 8'h06); idle(100);
        checkState("init");
        checkOutput("init_cmd_pulses", cmdPulses, 5);

        // 3: two characters, with same-cycle read of the written cell
        @(negedge clk);
        rd_addr = 5'd0;
        oldVal = mShadow[0];
        sendAndModel(1'b1, 8'h4C);
        checkOutput("rd_same_cycle_old", rd_char, oldVal);
        @(posedge clk); #1;
        checkOutput("rd_after_write", rd_char, mShadow[0]);
        sendAndModel(1'b1, 8'h4F);
        idle(2);
        readShadow(0, obs); checkOutput("char_L", obs, 8'h4C);
        readShadow(1, obs); checkOutput("char_O", obs, 8'h4F);
        checkOutput("cursor_after_LO", cursor_addr, 2);
        checkOutput("char_pulses", charPulses, 2);

        // 4: second line
        sendAndModel(1'b0, 8'hC0); idle(2);
        sendAndModel(1'b1, 8'h2B); idle(2);
        readShadow(16, obs); checkOutput("char_line2", obs, 8'h2B);
        checkOutput("cursor_line2", cursor_addr, 7'h41);

        // 5: line-end wraps and decrement wrap
        sendAndModel(1'b0, 8'hA7); idle(2);
        sendAndModel(1'b1, 8'h55); idle(2);
        checkOutput("wrap_27_to_40", cursor_addr, 7'h40);
        sendAndModel(1'b0, 8'hE7); idle(2);
        sendAndModel(1'b1, 8'h56); idle(2);
        checkOutput("wrap_67_to_00", cursor_addr, 7'h00);
        sendAndModel(1'b0, 8'h04); idle(2);
        sendAndModel(1'b0, 8'h80); idle(2);
        sendAndModel(1'b1, 8'h5A); idle(2);
        checkOutput("wrap_00_to_67", cursor_addr, 7'h67);
        checkShadowAll("wrap");
        sendAndModel(1'b0, 8'h06); idle(2);

        // Randomized strobes
        for (int n = 0; n < 50; n++) begin
            rs = ($urandom_range(0, 9) < 6);
            data = rs ? 8'($urandom_range(32, 126)) : 8'($urandom);
            if (!rs && $urandom_range(0, 3) == 0) data = 8'h80 | 8'($urandom_range(0, 127));
            sendAndModel(rs, data);
            idle(1);
            waitNotBusy();
            idle($urandom_range(0, 3));
            checkState($sformatf("rand%0d", n));
        end
        checkShadowAll("rand");
        checkOutput("rand_cmd_pulses", cmdPulses, mCmds);
        checkOutput("rand_char_pulses", charPulses, mChars);

        // 6: strobe during clear sweep is dropped and flagged
        waitNotBusy();
        sendAndModel(1'b0, 8'h01);
        applyStimulus(1'b1, 1'b0, 8'h41);
        mErr = 1'b1;
        idle(1);
        checkOutput("clear_strobe_err", protocol_err, 1);
        waitNotBusy();
        idle(2);
        checkState("after_clear_drop");
        checkOutput("clear_drop_chars", charPulses, mChars);

        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        modelReset();
        waitNotBusy();
        idle(1);
        checkOutput("err_cleared_by_rst", protocol_err, 0);
        applyStimulus(1'b1, 1'b1, 8'h42);
        mErr = 1'b1;
        idle(2);
        checkOutput("rw_strobe_err", protocol_err, 1);
        checkOutput("rw_drop_cursor", cursor_addr, 0);
        checkOutput("rw_drop_chars", charPulses, 0);
        readShadow(0, obs); checkOutput("rw_drop_store", obs, 8'h20);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
